instruction_memory_loader: RTL and testbench

Parametrised instruction memory with a byte-serial program loader, the successor to the IF-stage instruction memory. The debug/UART side streams a program one byte at a time; the block assembles 32-bit words, stores them sequentially, tracks the loaded word count and detects an end-of-program marker. The IF stage reads instructions asynchronously by PC. Any fetch outside the loaded program returns a NOP.

---
 rtl/mips_pkg.sv | 14 +
 rtl/instruction_memory_loader_byte_word_assembler.sv | 51 +++++
 rtl/instruction_memory_loader.sv | 103 ++++++++++
 tb/tb_instruction_memory_loader.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared constants and loader state encoding for the instruction memory
// and its byte-serial program loader.
package mips_pkg;

  localparam logic [31:0] NOP_WORD  = 32'h0000_0000;
  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    DONE = 2'd1,
    FULL = 2'd2
  } loader_state_t;

endpackage

// File: rtl/instruction_memory_loader_byte_word_assembler.sv
// Collects four accepted bytes into a 32-bit word. The completed word (with
// the current byte merged in) is presented combinationally with word_valid.
module byte_word_assembler #(
  parameter bit LITTLE_ENDIAN = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_clear,
  input  logic        i_byte_accept,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic        o_word_valid,
  output logic        o_pending
);

  logic [1:0]  byte_idx_q;
  logic [31:0] asm_q;
  logic [31:0] asm_next;
  logic [1:0]  lane;

  // Big-endian loading fills from the top lane downwards.
  assign lane = LITTLE_ENDIAN ? byte_idx_q : ~byte_idx_q;

  always_comb begin
    asm_next = asm_q;
    asm_next[{lane, 3'b000} +: 8] = i_byte;
  end

  assign o_word       = asm_next;
  assign o_word_valid = i_byte_accept && (byte_idx_q == 2'd3);
  assign o_pending    = (byte_idx_q != 2'd0);

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      byte_idx_q <= 2'd0;
      asm_q      <= 32'h0;
    end else if (i_clear) begin
      byte_idx_q <= 2'd0;
      asm_q      <= 32'h0;
    end else if (i_byte_accept) begin
      if (byte_idx_q == 2'd3) begin
        byte_idx_q <= 2'd0;
        asm_q      <= 32'h0;
      end else begin
        byte_idx_q <= byte_idx_q + 2'd1;
        asm_q      <= asm_next;
      end
    end
  end

endmodule

// File: rtl/instruction_memory_loader.sv
// Instruction memory filled by a byte-serial loader and read asynchronously
// by PC; fetches outside the loaded program return NOP_WORD.
module instruction_memory_loader
  import mips_pkg::*;
#(
  parameter int                         WORD_WIDTH_BITS = 32,
  parameter int                         MEM_SIZE_WORDS  = 64,
  parameter int                         PC_WIDTH        = 32,
  parameter bit                         LITTLE_ENDIAN   = 1'b1,
  parameter logic [WORD_WIDTH_BITS-1:0] HALT_WORD_P     = HALT_WORD,
  parameter logic [WORD_WIDTH_BITS-1:0] NOP_WORD_P      = NOP_WORD,
  parameter int                         COUNT_WIDTH     = $clog2(MEM_SIZE_WORDS + 1)
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_clear,
  input  logic                       i_byte_valid,
  input  logic [7:0]                 i_byte,
  output logic                       o_byte_ready,
  input  logic [PC_WIDTH-1:0]        i_pc,
  output logic [WORD_WIDTH_BITS-1:0] o_instruction,
  output logic                       o_pc_oob,
  output logic [COUNT_WIDTH-1:0]     o_word_count,
  output logic                       o_load_done,
  output logic                       o_full_mem,
  output logic                       o_empty_mem,
  output loader_state_t              o_dbg_state
);

  localparam int ADDR_W = $clog2(MEM_SIZE_WORDS);

  // Handshake: a byte transfers on a rising edge where i_byte_valid and
  // o_byte_ready are both high; the loader never waits on anything else.
  loader_state_t                state_q, state_d;
  logic [COUNT_WIDTH-1:0]       count_q;
  logic [COUNT_WIDTH-1:0]       count_inc;
  logic                         byte_accept;
  logic [WORD_WIDTH_BITS-1:0]   word;
  logic                         word_valid;
  logic                         pending;
  logic [PC_WIDTH-1:0]          fetch_idx;
  logic [WORD_WIDTH_BITS-1:0]   mem [MEM_SIZE_WORDS];

  assign byte_accept = i_byte_valid && o_byte_ready;
  assign count_inc   = count_q + COUNT_WIDTH'(1);

  byte_word_assembler #(
    .LITTLE_ENDIAN (LITTLE_ENDIAN)
  ) u_assembler (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_clear       (i_clear),
    .i_byte_accept (byte_accept),
    .i_byte        (i_byte),
    .o_word        (word),
    .o_word_valid  (word_valid),
    .o_pending     (pending)
  );

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= LOAD;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      if (i_clear) count_q <= '0;
      else if (word_valid) count_q <= count_inc;
    end
  end

  // HALT wins over FULL when the last free slot receives the marker.
  always_comb begin
    state_d = state_q;
    if (i_clear) begin
      state_d = LOAD;
    end else if (state_q == LOAD && word_valid) begin
      if (word == HALT_WORD_P) state_d = DONE;
      else if (count_inc == COUNT_WIDTH'(MEM_SIZE_WORDS)) state_d = FULL;
    end
  end

  always_comb begin
    o_byte_ready = 1'b0;
    o_load_done  = 1'b0;
    if (state_q == LOAD) o_byte_ready = !i_clear;
    else                 o_load_done  = 1'b1;
  end

  // The array is never cleared; the read guard hides stale words.
  always_ff @(posedge i_clk) begin
    if (word_valid) mem[count_q[ADDR_W-1:0]] <= word;
  end

  assign fetch_idx     = i_pc >> 2;
  assign o_pc_oob      = (i_pc[1:0] != 2'b00) || (fetch_idx >= PC_WIDTH'(count_q));
  assign o_instruction = o_pc_oob ? NOP_WORD_P : mem[fetch_idx[ADDR_W-1:0]];

  assign o_word_count = count_q;
  assign o_full_mem   = (count_q == COUNT_WIDTH'(MEM_SIZE_WORDS));
  assign o_empty_mem  = (count_q == '0) && !pending;
  assign o_dbg_state  = state_q;

endmodule

// File: tb/tb_instruction_memory_loader.sv
// Directed bench for instruction_memory_loader: little-endian (a), big-endian (b)
// and a 4-word memory (c) share one stimulus stream.
module tb_instruction_memory_loader;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr;
  logic        byte_valid;
  logic [7:0]  byte_in;
  logic [31:0] pc;

  logic        ready_a, ready_b, ready_c;
  logic [31:0] instr_a, instr_b, instr_c;
  logic        oob_a, oob_b, oob_c;
  logic [6:0]  cnt_a, cnt_b;
  logic [2:0]  cnt_c;
  logic        done_a, done_b, done_c;
  logic        full_a, full_b, full_c;
  logic        empty_a, empty_b, empty_c;
  loader_state_t st_a, st_b, st_c;

  logic [31:0] exp_q[$];
  logic [31:0] w;
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  instruction_memory_loader #(.LITTLE_ENDIAN(1'b1)) dut_a (
    .i_clk(clk), .i_reset(rst_n), .i_clear(clr), .i_byte_valid(byte_valid), .i_byte(byte_in),
    .o_byte_ready(ready_a), .i_pc(pc), .o_instruction(instr_a), .o_pc_oob(oob_a),
    .o_word_count(cnt_a), .o_load_done(done_a), .o_full_mem(full_a), .o_empty_mem(empty_a),
    .o_dbg_state(st_a));

  instruction_memory_loader #(.LITTLE_ENDIAN(1'b0)) dut_b (
    .i_clk(clk), .i_reset(rst_n), .i_clear(clr), .i_byte_valid(byte_valid), .i_byte(byte_in),
    .o_byte_ready(ready_b), .i_pc(pc), .o_instruction(instr_b), .o_pc_oob(oob_b),
    .o_word_count(cnt_b), .o_load_done(done_b), .o_full_mem(full_b), .o_empty_mem(empty_b),
    .o_dbg_state(st_b));

  instruction_memory_loader #(.MEM_SIZE_WORDS(4)) dut_c (
    .i_clk(clk), .i_reset(rst_n), .i_clear(clr), .i_byte_valid(byte_valid), .i_byte(byte_in),
    .o_byte_ready(ready_c), .i_pc(pc), .o_instruction(instr_c), .o_pc_oob(oob_c),
    .o_word_count(cnt_c), .o_load_done(done_c), .o_full_mem(full_c), .o_empty_mem(empty_c),
    .o_dbg_state(st_c));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called on a falling edge; returns on the next falling edge.
  task automatic send_byte(input logic [7:0] b);
    byte_in    = b;
    byte_valid = 1'b1;
    @(negedge clk);
  endtask

  // Sends one word in arrival order; expected little-endian packing is queued.
  task automatic send_word(input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input logic [7:0] b3);
    send_byte(b0);
    send_byte(b1);
    send_byte(b2);
    send_byte(b3);
    byte_valid = 1'b0;
    exp_q.push_back({b3, b2, b1, b0});
  endtask

  task automatic send_rand_word();
    send_word(8'($urandom_range(0, 254)), 8'($urandom_range(0, 255)),
              8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
  endtask

  task automatic pulse_clear();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic set_pc(input logic [31:0] p);
    pc = p;
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ready"}, 32'(ready_a), 32'd1);
    check({tag, "_cnt"},   32'(cnt_a),   32'd0);
    check({tag, "_done"},  32'(done_a),  32'd0);
    check({tag, "_full"},  32'(full_a),  32'd0);
    check({tag, "_empty"}, 32'(empty_a), 32'd1);
    check({tag, "_oob"},   32'(oob_a),   32'd1);
    check({tag, "_instr"}, instr_a,      NOP_WORD);
    check({tag, "_state"}, 32'(st_a),    32'(LOAD));
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; byte_valid = 1'b0; byte_in = 8'h00; pc = 32'h0;
    #2;
    check_reset_values("rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // First word and endianness
    send_word(8'h20, 8'h01, 8'h00, 8'h05);
    check("w0_cnt", 32'(cnt_a), 32'd1);
    check("w0_empty", 32'(empty_a), 32'd0);
    set_pc(32'd0);
    check("w0_le", instr_a, 32'h0500_0120);
    check("w0_be", instr_b, 32'h2001_0005);
    check("w0_oob", 32'(oob_a), 32'd0);
    set_pc(32'd4);
    check("pc4_nop", instr_a, NOP_WORD);
    check("pc4_oob", 32'(oob_a), 32'd1);
    set_pc(32'd2);
    check("pc2_nop", instr_a, NOP_WORD);
    check("pc2_oob", 32'(oob_a), 32'd1);

    // Fill the 4-word memory
    repeat (3) send_rand_word();
    check("c_full_cnt", 32'(cnt_c), 32'd4);
    check("c_full", 32'(full_c), 32'd1);
    check("c_full_done", 32'(done_c), 32'd1);
    check("c_full_ready", 32'(ready_c), 32'd0);
    check("c_full_state", 32'(st_c), 32'(FULL));
    check("a_cnt4", 32'(cnt_a), 32'd4);
    check("a_not_done", 32'(done_a), 32'd0);
    for (int i = 0; i < 4; i++) begin
      w = exp_q.pop_front();
      set_pc(32'(i * 4));
      check("a_read", instr_a, w);
      if (i == 3) check("c_pc12", instr_c, w);
    end
    set_pc(32'd16);
    check("c_pc16_nop", instr_c, NOP_WORD);
    check("c_pc16_oob", 32'(oob_c), 32'd1);
    send_byte(8'h33);
    byte_valid = 1'b0;
    check("c_ignored_cnt", 32'(cnt_c), 32'd4);

    // Halt marker stops loading
    pulse_clear();
    check("clr_cnt", 32'(cnt_a), 32'd0);
    check("clr_empty", 32'(empty_a), 32'd1);
    check("clr_c_done", 32'(done_c), 32'd0);
    send_rand_word();
    send_rand_word();
    send_word(8'hFF, 8'hFF, 8'hFF, 8'hFF);
    check("halt_cnt", 32'(cnt_a), 32'd3);
    check("halt_done", 32'(done_a), 32'd1);
    check("halt_full", 32'(full_a), 32'd0);
    check("halt_ready", 32'(ready_a), 32'd0);
    check("halt_state", 32'(st_a), 32'(DONE));
    check("halt_c_full", 32'(full_c), 32'd0);
    send_byte(8'h12);
    byte_valid = 1'b0;
    check("halt_ignored_cnt", 32'(cnt_a), 32'd3);
    for (int i = 0; i < 3; i++) begin
      w = exp_q.pop_front();
      set_pc(32'(i * 4));
      check("halt_read", instr_a, w);
    end
    set_pc(32'd12);
    check("halt_pc12_oob", 32'(oob_a), 32'd1);

    // Halt lands in the last slot: DONE wins, full still flagged
    pulse_clear();
    repeat (3) send_rand_word();
    send_word(8'hFF, 8'hFF, 8'hFF, 8'hFF);
    check("hf_state", 32'(st_c), 32'(DONE));
    check("hf_full", 32'(full_c), 32'd1);
    check("hf_done", 32'(done_c), 32'd1);
    for (int i = 0; i < 4; i++) begin
      w = exp_q.pop_front();
      set_pc(32'(i * 4));
      check("hf_read", instr_c, w);
    end

    // Clear during a partial word drops the partial and the concurrent byte
    pulse_clear();
    send_byte(8'hA1);
    send_byte(8'hA2);
    clr = 1'b1;
    byte_in = 8'hA3;
    #1;
    check("clr_ready_low", 32'(ready_a), 32'd0);
    @(negedge clk);
    clr = 1'b0;
    byte_valid = 1'b0;
    check("pclr_cnt", 32'(cnt_a), 32'd0);
    check("pclr_empty", 32'(empty_a), 32'd1);
    send_word(8'h13, 8'h57, 8'h9B, 8'hDF);
    check("pclr_cnt1", 32'(cnt_a), 32'd1);
    w = exp_q.pop_front();
    set_pc(32'd0);
    check("pclr_word0", instr_a, w);

    // Asynchronous reset mid-word
    send_byte(8'h44);
    send_byte(8'h55);
    byte_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    pc = 32'd0;
    #1;
    check_reset_values("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;

    // Asynchronous reset from DONE
    send_word(8'hFF, 8'hFF, 8'hFF, 8'hFF);
    w = exp_q.pop_front();
    check("done_before_rst", 32'(done_a), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("rst_done");
    check("rst_done_q", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
